// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle for the stream reader: Avalon-MM read side toward the on-chip RAM
// and the valid/ready pixel stream toward the HDMI formatter.
interface onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output mem_address, mem_chipselect,
    input  mem_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  mem_address, mem_chipselect,
    output mem_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Reads word_count consecutive words from the on-chip RAM with fixed-latency
// reads, buffers them in a small FIFO and streams them out with sop/eop framing.
module onchip_mem_stream_reader #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           word_count,
  output logic                       busy,
  output logic                       done,
  onchip_mem_stream_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_W-1:0]       ptr_r;
  logic [CNT_W-1:0]        issue_cnt_r;
  logic [CNT_W-1:0]        deliv_cnt_r;
  logic                    first_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    mem_cs_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [READ_LATENCY-1:0] rd_pipe_r;
  logic [DATA_W-1:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [OCC_W-1:0]        fifo_cnt_r;
  logic [OCC_W-1:0]        inflight_s;
  logic                    accept_s;
  logic                    issue_s;
  logic                    done_nxt_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    valid_s;
  logic                    last_pop_s;
  logic                    credit_ok_s;

  // Reads in flight: the registered strobe plus every stage of the return pipe.
  always_comb begin
    inflight_s = OCC_W'(mem_cs_r);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + OCC_W'(rd_pipe_r[i]);
    end
  end

  // FIFO handshakes and the issue credit, which counts this cycle's pop.
  always_comb begin
    valid_s     = (fifo_cnt_r != {OCC_W{1'b0}});
    pop_s       = valid_s & bus.src_ready;
    push_s      = rd_pipe_r[READ_LATENCY-1];
    last_pop_s  = pop_s & (deliv_cnt_r == CNT_W'(1));
    credit_ok_s = (fifo_cnt_r + inflight_s) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop_s));
  end

  // Next-state and per-cycle command decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count != {CNT_W{1'b0}}) begin
            accept_s    = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            done_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if ((issue_cnt_r != {CNT_W{1'b0}}) && credit_ok_s) begin
          issue_s = 1'b1;
          if (issue_cnt_r == CNT_W'(1)) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = ISSUE;
          end
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (last_pop_s) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transfer bookkeeping: address pointer, counters, sop flag, busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r       <= {ADDR_W{1'b0}};
      issue_cnt_r <= {CNT_W{1'b0}};
      deliv_cnt_r <= {CNT_W{1'b0}};
      first_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= done_nxt_s;
      if (accept_s) begin
        ptr_r       <= base_addr;
        issue_cnt_r <= word_count;
        deliv_cnt_r <= word_count;
        first_r     <= 1'b1;
      end else begin
        if (issue_s) begin
          ptr_r       <= ptr_r + ADDR_W'(1);
          issue_cnt_r <= issue_cnt_r - CNT_W'(1);
        end
        if (pop_s) begin
          deliv_cnt_r <= deliv_cnt_r - CNT_W'(1);
          first_r     <= 1'b0;
        end
      end
    end
  end

  // Registered RAM strobe/address and the read-return valid pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cs_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      rd_pipe_r  <= {READ_LATENCY{1'b0}};
    end else begin
      mem_cs_r     <= issue_s;
      rd_pipe_r[0] <= mem_cs_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
      if (issue_s) begin
        mem_addr_r <= ptr_r;
      end
    end
  end

  // Buffer storage; returning data is captured unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.mem_readdata;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + OCC_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - OCC_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign bus.mem_address    = mem_addr_r;
  assign bus.mem_chipselect = mem_cs_r;
  assign bus.src_data       = fifo_mem_r[rd_ptr_r];
  assign bus.src_valid      = valid_s;
  assign bus.src_sop        = valid_s & first_r;
  assign bus.src_eop        = valid_s & (deliv_cnt_r == CNT_W'(1));
  assign busy               = busy_r;
  assign done               = done_r;
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Randomized bench for onchip_mem_stream_reader: a RAM model, a queue-based
// transfer model checked every cycle, plus literal expectations per scenario.
module tb_onchip_mem_stream_reader;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
  localparam int DEPTH     = 8;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              sop;
    logic              eop;
  } beat_t;

  logic              clk        = 1'b0;
  logic              reset      = 1'b0;
  logic              start      = 1'b0;
  logic [ADDR_W-1:0] base_addr  = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] ram [MEM_WORDS];

  onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM: registered address, unregistered data -> one clock of read latency.
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];
  end

  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] rx_log[$];
  logic [ADDR_W-1:0] cs_log[$];
  bit                m_active = 0, exp_busy = 0, exp_done = 0, prev_stall = 0, lat_pending = 0;
  logic [DATA_W-1:0] prev_data = '0;
  int issued = 0, delivered = 0, done_cnt = 0, busy_cnt = 0, sopeop_cnt = 0;
  int start_cyc = 0, latency = -1, ready_mode = 0, ready_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    beat_t             b;
    beat_t             nb;
    bit                popped_eop;
    bit                was_active;
    int                n;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("reset_outputs", 64'({busy, done, bus.mem_chipselect, bus.src_valid, bus.src_sop,
                                  bus.src_eop, bus.mem_address, bus.src_data}), 64'(0));
        exp_q.delete(); addr_q.delete();
        m_active = 0; exp_busy = 0; exp_done = 0; prev_stall = 0; lat_pending = 0;
        issued = 0; delivered = 0;
      end else begin
        popped_eop = 1'b0;
        was_active = m_active;
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (bus.mem_chipselect) begin
          issued++;
          cs_log.push_back(bus.mem_address);
          chk("chipselect_expected", 64'(addr_q.size() != 0), 64'(1));
          if (addr_q.size() != 0) chk("mem_address", 64'(bus.mem_address), 64'(addr_q.pop_front()));
        end
        if (prev_stall) chk("stall_hold", 64'({bus.src_valid, bus.src_data}), 64'({1'b1, prev_data}));
        if (bus.src_valid) begin
          chk("valid_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            b = exp_q[0];
            chk("src_data", 64'(bus.src_data), 64'(b.d));
            chk("src_sop", 64'(bus.src_sop), 64'(b.sop));
            chk("src_eop", 64'(bus.src_eop), 64'(b.eop));
            if (lat_pending) begin
              latency     = cyc - start_cyc;
              lat_pending = 0;
            end
            if (bus.src_ready) begin
              void'(exp_q.pop_front());
              rx_log.push_back(bus.src_data);
              delivered++;
              if (bus.src_sop && bus.src_eop) sopeop_cnt++;
              popped_eop = b.eop;
            end
          end
        end
        chk("credit", 64'((issued - delivered) <= DEPTH), 64'(1));
        prev_stall = bus.src_valid && !bus.src_ready;
        prev_data  = bus.src_data;
        // Expected behaviour for the next cycle.
        exp_done = 1'b0;
        if (was_active && popped_eop) begin
          m_active = 0;
          exp_done = 1;
        end
        if (!was_active && start) begin
          n = int'(word_count);
          if (n == 0) begin
            exp_done = 1;
          end else begin
            m_active = 1;
            for (int i = 0; i < n; i++) begin
              a      = base_addr + ADDR_W'(i);
              nb.d   = ram[a];
              nb.sop = (i == 0);
              nb.eop = (i == n - 1);
              addr_q.push_back(a);
              exp_q.push_back(nb);
            end
            start_cyc   = cyc;
            lat_pending = 1;
          end
        end
        exp_busy = m_active;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.src_ready = 1'b1;
        1:       bus.src_ready = (int'($urandom_range(0, 99)) < ready_pct);
        2:       bus.src_ready = ~bus.src_ready;
        default: bus.src_ready = 1'b0;
      endcase
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    start = 1'b1; base_addr = a; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while ((m_active || exp_q.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    chk({name, "_complete"}, 64'(k < limit), 64'(1));
    repeat (3) tick();
  endtask

  task automatic clear_logs();
    rx_log.delete(); cs_log.delete();
    done_cnt = 0; busy_cnt = 0; sopeop_cnt = 0; latency = -1;
  endtask

  initial begin
    logic [DATA_W-1:0] basic_exp [4];
    logic [ADDR_W-1:0] wrap_addr [4];
    logic [DATA_W-1:0] wrap_data [4];
    logic [DATA_W-1:0] after_rst [3];
    int                k;
    int                n;
    logic [ADDR_W-1:0] rb;

    basic_exp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    wrap_addr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    wrap_data = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
    bus.src_ready = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram[15'h0100 + ADDR_W'(i)] = basic_exp[i];
    for (int i = 0; i < 4; i++) ram[wrap_addr[i]] = wrap_data[i];
    for (int i = 0; i < 3; i++) after_rst[i] = ram[15'h0800 + ADDR_W'(i)];

    fork
      monitor();
      ready_driver();
    join_none

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Basic 4-word read at full rate.
    clear_logs(); ready_mode = 0;
    do_start(15'h0100, 16'd4);
    wait_idle("basic", 100);
    chk("basic_beats", 64'(rx_log.size()), 64'(4));
    for (int i = 0; i < rx_log.size() && i < 4; i++) chk("basic_word", 64'(rx_log[i]), 64'(basic_exp[i]));
    chk("basic_chipselect_cycles", 64'(cs_log.size()), 64'(4));
    chk("basic_done_pulses", 64'(done_cnt), 64'(1));
    chk("basic_latency", 64'(latency), 64'(4));

    // Backpressure: toggling ready, then a long stall that fills the buffer.
    clear_logs(); ready_mode = 2;
    do_start(15'h2000, 16'd20);
    repeat (12) tick();
    ready_mode = 3;
    repeat (15) tick();
    chk("backpressure_fill", 64'(issued - delivered), 64'(DEPTH));
    ready_mode = 0;
    wait_idle("backpressure", 300);
    chk("backpressure_beats", 64'(rx_log.size()), 64'(20));
    chk("backpressure_chipselects", 64'(cs_log.size()), 64'(20));
    chk("backpressure_done", 64'(done_cnt), 64'(1));

    // Address wrap at the top of the RAM.
    clear_logs();
    do_start(15'h7FFE, 16'd4);
    wait_idle("wrap", 100);
    chk("wrap_beats", 64'(rx_log.size()), 64'(4));
    for (int i = 0; i < cs_log.size() && i < 4; i++) chk("wrap_addr", 64'(cs_log[i]), 64'(wrap_addr[i]));
    for (int i = 0; i < rx_log.size() && i < 4; i++) chk("wrap_data", 64'(rx_log[i]), 64'(wrap_data[i]));

    // Zero-length and single-word transfers.
    clear_logs();
    do_start(15'h0050, 16'd0);
    wait_idle("zero", 20);
    chk("zero_chipselects", 64'(cs_log.size()), 64'(0));
    chk("zero_done", 64'(done_cnt), 64'(1));
    chk("zero_busy_cycles", 64'(busy_cnt), 64'(0));
    clear_logs();
    do_start(15'h0060, 16'd1);
    wait_idle("single", 50);
    chk("single_beats", 64'(rx_log.size()), 64'(1));
    chk("single_sop_eop", 64'(sopeop_cnt), 64'(1));

    // A start while busy is ignored.
    clear_logs(); ready_mode = 1; ready_pct = 50;
    do_start(15'h0300, 16'd10);
    repeat (3) tick();
    do_start(15'h0400, 16'd5);
    wait_idle("ignored_start", 300);
    chk("ignored_start_beats", 64'(rx_log.size()), 64'(10));
    chk("ignored_start_chipselects", 64'(cs_log.size()), 64'(10));
    chk("ignored_start_done", 64'(done_cnt), 64'(1));

    // A start presented in the done cycle is accepted.
    clear_logs(); ready_mode = 0;
    do_start(15'h0500, 16'd3);
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("done_seen", 64'(done), 64'(1));
    do_start(15'h0600, 16'd2);
    wait_idle("done_cycle_start", 100);
    chk("done_cycle_beats", 64'(rx_log.size()), 64'(5));
    chk("done_cycle_done", 64'(done_cnt), 64'(2));
    if (cs_log.size() > 3) chk("done_cycle_addr", 64'(cs_log[3]), 64'(15'h0600));
    else chk("done_cycle_addr_count", 64'(cs_log.size()), 64'(5));

    // Reset in the middle of a transfer.
    clear_logs();
    do_start(15'h0700, 16'd16);
    k = 0;
    while (rx_log.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    chk("reset_point_reached", 64'(rx_log.size() >= 5), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("reset_immediate", 64'({busy, done, bus.mem_chipselect, bus.src_valid, bus.src_sop,
                                bus.src_eop, bus.mem_address, bus.src_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("reset_no_done", 64'(done_cnt), 64'(0));
    clear_logs();
    do_start(15'h0800, 16'd3);
    wait_idle("after_reset", 100);
    chk("after_reset_beats", 64'(rx_log.size()), 64'(3));
    for (int i = 0; i < rx_log.size() && i < 3; i++) chk("after_reset_word", 64'(rx_log[i]), 64'(after_rst[i]));
    chk("after_reset_done", 64'(done_cnt), 64'(1));

    // Randomized transfers with random backpressure and ignored restarts.
    for (int t = 0; t < 10; t++) begin
      clear_logs();
      ready_mode = 1;
      ready_pct  = int'($urandom_range(30, 100));
      rb         = ADDR_W'($urandom);
      n          = int'($urandom_range(1, 40));
      do_start(rb, CNT_W'(n));
      if (n >= 10 && $urandom_range(0, 1) == 1) begin
        tick();
        do_start(ADDR_W'($urandom), CNT_W'($urandom_range(1, 40)));
      end
      wait_idle("random", 600);
      chk("random_beats", 64'(rx_log.size()), 64'(n));
      chk("random_done", 64'(done_cnt), 64'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/onchip_mem_stream_reader.md
Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the pixel path and downstream of the 32-bit single-port on-chip RAM: the Nios II writes pixel/line data into the RAM, and this block reads it out.
- On a start command it reads word_count consecutive 32-bit words from base_addr using fixed-latency reads.
- It buffers the words in a small internal FIFO and presents them on a valid/ready stream, with start-of-packet and end-of-packet flags, to the HDMI pixel formatter.

Parameters:
- ADDR_W, 15, word-address width of the RAM slave.
- DATA_W, 32, data width of the RAM and of the stream.
- CNT_W, 16, width of word_count; supports 0..2^CNT_W-1 words.
- FIFO_DEPTH, 8, internal buffer entries; power of two, minimum 4.
- READ_LATENCY, 1, clocks from address/chipselect to valid mem_readdata; the RAM's address is registered and its output is unregistered.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured on an accepted start.
- word_count  in  CNT_W  number of words to read; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word is accepted on the stream.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  read strobe; mem_write is tied 0 and mem_byteenable is tied all-ones outside this block.
- mem_readdata  in  DATA_W  RAM read data.
- src_data  out  DATA_W  stream data.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready from the consumer.
- src_sop  out  1  asserted with the first word of a transfer.
- src_eop  out  1  asserted with the last word of a transfer.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, src_valid=0, src_sop=0, src_eop=0, src_data=0. The FIFO, in-flight pipeline, counters and FSM are cleared and the FSM enters IDLE.
- Reset mid-transfer: the transfer is abandoned, any in-flight read data is discarded, and no done pulse is issued.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on start with word_count != 0. Latch the address pointer = base_addr, issue counter = word_count and delivery counter = word_count.
- IDLE with start and word_count == 0: no reads are issued; done pulses on the next cycle; busy stays 0.
- start is ignored outside IDLE.
- Read issue (ISSUE state): mem_chipselect=1 in a cycle only if the issue counter != 0 AND (FIFO occupancy + reads in flight) < FIFO_DEPTH.
- On each issue: the pointer increments by 1, modulo 2^ADDR_W (wraps from 0x7FFF to 0x0000), and the issue counter decrements.
- mem_address and mem_chipselect are registered outputs.
- ISSUE -> DRAIN in the cycle after the final issue.
- Read return: a READ_LATENCY-deep valid shift register tracks in-flight reads. When its tap is set, mem_readdata is written into the FIFO in that cycle. With no stall path on the RAM, capture is unconditional; the credit check guarantees the FIFO never overflows.
- Stream output:
  - src_valid = FIFO not empty; src_data = FIFO head, with no combinational path from mem_readdata.
  - A word transfers when src_valid & src_ready; the delivery counter then decrements.
  - src_valid must not drop, and src_data must not change, while src_valid=1 and src_ready=0.
  - src_sop=1 on the first word of a transfer; src_eop=1 when the delivery counter == 1. For a 1-word transfer both are high on the same word.
- DRAIN -> IDLE on the transfer of the eop word. done=1 for exactly that next cycle and busy falls in the same cycle. A new start is accepted on the cycle done is high.
- Simultaneous FIFO write and read: both occur and occupancy is unchanged. The credit check counts the pop in the same cycle, so the FIFO sustains 1 word/clk throughput when src_ready is held high.
- Steady-state throughput: 1 word per clock. Latency from the start pulse to the first src_valid is 1 (latch) + 1 (address register) + READ_LATENCY + 1 (FIFO write) = 4 clocks at defaults.

Test Plan:
- Basic 4-word read: RAM preloaded with 0x11111111..0x44444444 at 0x0100..0x0103; start with base_addr=0x0100, word_count=4, src_ready=1 -> 4 consecutive beats in order; sop on beat 0; eop on beat 3; done pulses once; mem_chipselect high for exactly 4 cycles.
- Backpressure: word_count=20, src_ready toggling 1/0, then held 0 for 15 cycles -> total in-flight plus buffered never exceeds 8; no data lost or duplicated; data held stable while stalled; all 20 words arrive in order.
- Address wrap: base_addr=0x7FFE, word_count=4 -> reads addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; stream data matches those locations.
- Zero and single length: word_count=0 -> no chipselect; done one cycle after start; busy stays 0. word_count=1 -> a single beat with sop=eop=1.
- Start while busy: a second start mid-transfer with different base_addr and count -> ignored; the original transfer completes unchanged. A start asserted on the cycle done is high -> accepted.
- Reset mid-transfer: assert reset after 5 of 16 words -> all outputs return to reset values immediately; no done pulse. A fresh 3-word start afterwards -> exactly 3 correct words, with no stale data appearing.
